// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared operation encoding and size defaults for the accumulator bank
//
// Purpose : op typedef and constants (ACC_LOAD/ACC_ADD/ACC_SUB/ACC_CLR) plus the
//           default WIDTH/DEPTH used by acc_bank and acc_alu.
// Ports   : none (package).
// Config  : ACC_SAT_EN is consumed by acc_alu, not here.
package acc_pkg;

    typedef enum logic [1:0] {
        ACC_LOAD = 2'b00,
        ACC_ADD  = 2'b01,
        ACC_SUB  = 2'b10,
        ACC_CLR  = 2'b11
    } acc_op_t;

    localparam int ACC_WIDTH_DEF = 16;
    localparam int ACC_DEPTH_DEF = 4;

endpackage

// File: rtl/acc_alu.sv
// rtl/acc_alu.sv - combinational result and status computation for one accumulator store
//
// Purpose : computes the value written by a store and its zero/neg/carry/ovf flags.
// Ports   : acc     in  WIDTH  current accumulator value
//           operand in  WIDTH  ALU result operand
//           op      in  2      LOAD/ADD/SUB/CLR
//           result  out WIDTH  value to write
//           zero, neg, carry, ovf out 1  status of result
// Config  : ACC_SAT_EN - clamp signed-overflowing ADD/SUB to the signed range limit;
//           otherwise results wrap modulo 2^WIDTH.
module acc_alu
    import acc_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] operand,
    input  acc_op_t          op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] raw;
    logic             ovf_raw;

    always_comb begin
        sum     = {1'b0, acc} + {1'b0, operand};
        // Bit WIDTH of the extended difference is the unsigned borrow (operand > acc).
        diff    = {1'b0, acc} - {1'b0, operand};
        raw     = '0;
        carry   = 1'b0;
        ovf_raw = 1'b0;
        case (op)
            ACC_LOAD: raw = operand;
            ACC_ADD: begin
                raw     = sum[WIDTH-1:0];
                carry   = sum[WIDTH];
                ovf_raw = (acc[MSB] == operand[MSB]) && (sum[MSB] != acc[MSB]);
            end
            ACC_SUB: begin
                raw     = diff[WIDTH-1:0];
                carry   = diff[WIDTH];
                ovf_raw = (acc[MSB] != operand[MSB]) && (diff[MSB] != acc[MSB]);
            end
            default: raw = '0;
        endcase
        ovf = ovf_raw;
`ifdef ACC_SAT_EN
        // Overflow direction follows the sign of acc: a non-negative acc can only
        // overflow upward, a negative one only downward, for both ADD and SUB.
        if (ovf_raw)
            result = acc[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            result = raw;
`else
        result = raw;
`endif
        zero = (result == '0);
        neg  = result[MSB];
    end

endmodule

// File: rtl/acc_bank.sv
// rtl/acc_bank.sv - bank of DEPTH accumulators with strobed ALU store and registered read port
//
// Purpose : holds the accumulators, decodes the store target, and registers the selected
//           accumulator (write-through) plus the status of the last executed store.
// Ports   : clk      in  1      clock
//           reset    in  1      synchronous active-high reset
//           ALU_rez  in  WIDTH  ALU result operand
//           str_rez  in  1      store strobe
//           op       in  2      LOAD=00 ADD=01 SUB=10 CLR=11
//           wsel     in  clog2(DEPTH)  accumulator written (>= DEPTH ignored)
//           rsel     in  clog2(DEPTH)  accumulator driven on out (>= DEPTH reads 0)
//           out      out WIDTH  registered acc[rsel]
//           zero, neg, carry, ovf out 1  status of last executed store
// Config  : ACC_SAT_EN (see acc_alu) selects saturating ADD/SUB.
module acc_bank
    import acc_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH_DEF,
    parameter int DEPTH = ACC_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         ALU_rez,
    input  logic                     str_rez,
    input  logic [1:0]               op,
    input  logic [$clog2(DEPTH)-1:0] wsel,
    input  logic [$clog2(DEPTH)-1:0] rsel,
    output logic [WIDTH-1:0]         out,
    output logic                     zero,
    output logic                     neg,
    output logic                     carry,
    output logic                     ovf
);

    localparam int SW = $clog2(DEPTH);
    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [SW:0] DEPTH_W = (SW+1)'(DEPTH);

    logic [WIDTH-1:0] acc      [DEPTH];
    logic [WIDTH-1:0] acc_next [DEPTH];
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] rd_next;
    logic             wr_en;
    logic             alu_zero;
    logic             alu_neg;
    logic             alu_carry;
    logic             alu_ovf;

    assign wr_en = str_rez && ({1'b0, wsel} < DEPTH_W);

    // Decoded with compare loops so out-of-range selects never index past the array.
    always_comb begin
        cur = '0;
        for (int i = 0; i < DEPTH; i++)
            if (wsel == SW'(i)) cur = acc[i];
    end

    acc_alu #(.WIDTH(WIDTH)) u_alu (
        .acc     (cur),
        .operand (ALU_rez),
        .op      (acc_op_t'(op)),
        .result  (result),
        .zero    (alu_zero),
        .neg     (alu_neg),
        .carry   (alu_carry),
        .ovf     (alu_ovf)
    );

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            acc_next[i] = (wr_en && (wsel == SW'(i))) ? result : acc[i];
    end

    // Reading from the post-store values gives write-through on the output register.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < DEPTH; i++)
            if (rsel == SW'(i)) rd_next = acc_next[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
            out   <= '0;
            zero  <= 1'b0;
            neg   <= 1'b0;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) acc[i] <= acc_next[i];
            out <= rd_next;
            if (wr_en) begin
                zero  <= alu_zero;
                neg   <= alu_neg;
                carry <= alu_carry;
                ovf   <= alu_ovf;
            end
        end
    end

endmodule

// File: tb/tb_acc_bank.sv
// tb/tb_acc_bank.sv - self-checking bench for acc_bank (DEPTH=4 and DEPTH=3 instances)
module tb_acc_bank;
    import acc_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] alu_rez;
    logic         str_rez;
    logic [1:0]   op;
    logic [1:0]   wsel;
    logic [1:0]   rsel;

    logic [W-1:0] out4, out3;
    logic         zero4, neg4, carry4, ovf4;
    logic         zero3, neg3, carry3, ovf3;

    always #5 clk = ~clk;

    acc_bank #(.WIDTH(W), .DEPTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .ALU_rez(alu_rez), .str_rez(str_rez), .op(op),
        .wsel(wsel), .rsel(rsel), .out(out4),
        .zero(zero4), .neg(neg4), .carry(carry4), .ovf(ovf4)
    );

    acc_bank #(.WIDTH(W), .DEPTH(3)) u_dut3 (
        .clk(clk), .reset(reset), .ALU_rez(alu_rez), .str_rez(str_rez), .op(op),
        .wsel(wsel), .rsel(rsel), .out(out3),
        .zero(zero3), .neg(neg3), .carry(carry3), .ovf(ovf3)
    );

    int errors = 0;
    int checks = 0;
    int step   = 0;

    // Reference model: index 0 models DEPTH=4, index 1 models DEPTH=3.
    int m_acc [2][4];
    int m_out [2];
    bit m_z [2];
    bit m_n [2];
    bit m_c [2];
    bit m_v [2];

    function automatic int depth_of(int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int to_signed(int u);
        return (u >= 32768) ? u - 65536 : u;
    endfunction

    task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, step, obs, exp);
        end
    endtask

    task automatic model_edge();
        int a, b, r, s;
        bit c, v;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                for (int i = 0; i < 4; i++) m_acc[d][i] = 0;
                m_out[d] = 0;
                m_z[d] = 0; m_n[d] = 0; m_c[d] = 0; m_v[d] = 0;
            end else begin
                if (str_rez && int'(wsel) < depth_of(d)) begin
                    a = m_acc[d][wsel];
                    b = int'(alu_rez);
                    s = 0; c = 0; v = 0; r = 0;
                    case (op)
                        2'b00: r = b;
                        2'b01: begin
                            r = (a + b) % 65536;
                            c = (a + b) > 65535;
                            s = to_signed(a) + to_signed(b);
                            v = (s > 32767) || (s < -32768);
                        end
                        2'b10: begin
                            r = (a - b + 65536) % 65536;
                            c = b > a;
                            s = to_signed(a) - to_signed(b);
                            v = (s > 32767) || (s < -32768);
                        end
                        default: r = 0;
                    endcase
`ifdef ACC_SAT_EN
                    if (v) r = (s > 32767) ? 32767 : 32768;
`endif
                    m_acc[d][wsel] = r;
                    m_z[d] = (r == 0);
                    m_n[d] = (r >= 32768);
                    m_c[d] = c;
                    m_v[d] = v;
                end
                m_out[d] = (int'(rsel) < depth_of(d)) ? m_acc[d][rsel] : 0;
            end
        end
    endtask

    task automatic check_all();
        check("out4",   out4,   W'(m_out[0]));
        check("zero4",  W'(zero4),  W'(m_z[0]));
        check("neg4",   W'(neg4),   W'(m_n[0]));
        check("carry4", W'(carry4), W'(m_c[0]));
        check("ovf4",   W'(ovf4),   W'(m_v[0]));
        check("out3",   out3,   W'(m_out[1]));
        check("zero3",  W'(zero3),  W'(m_z[1]));
        check("neg3",   W'(neg3),   W'(m_n[1]));
        check("carry3", W'(carry3), W'(m_c[1]));
        check("ovf3",   W'(ovf3),   W'(m_v[1]));
    endtask

    task automatic drive(bit rst, bit s, logic [1:0] o, logic [W-1:0] v,
                         logic [1:0] ws, logic [1:0] rs);
        reset = rst; str_rez = s; op = o; alu_rez = v; wsel = ws; rsel = rs;
        @(posedge clk);
        model_edge();
        #1;
        step++;
        check_all();
    endtask

    initial begin
        logic [W-1:0] edge_vals [6];
        edge_vals[0] = 16'h0000; edge_vals[1] = 16'h0001; edge_vals[2] = 16'h7FFF;
        edge_vals[3] = 16'h8000; edge_vals[4] = 16'hFFFF; edge_vals[5] = 16'h8001;

        reset = 1'b1; str_rez = 1'b0; op = 2'b00; alu_rez = '0; wsel = '0; rsel = '0;
        #1;

        // Reset wins over a simultaneous store.
        drive(1, 1, ACC_LOAD, 16'h0FFF, 2'd0, 2'd0);
        check("rst_out", out4, 16'h0000);
        check("rst_flags", W'({zero4, neg4, carry4, ovf4}), 16'h0000);

        // LOAD 0xFFFF then hold for two idle cycles.
        drive(0, 1, ACC_LOAD, 16'hFFFF, 2'd0, 2'd0);
        drive(0, 0, ACC_LOAD, 16'hFF01, 2'd0, 2'd0);
        drive(0, 0, ACC_LOAD, 16'hFF01, 2'd0, 2'd0);
        check("hold_out", out4, 16'hFFFF);
        check("hold_neg_zero", W'({neg4, zero4}), 16'h0002);

        // ADD wraps to zero with carry.
        drive(0, 1, ACC_ADD, 16'h0001, 2'd0, 2'd0);
        check("add_wrap", W'({out4[3:0], zero4, carry4, ovf4}), 16'h0006);

        // Signed overflow on acc1.
        drive(0, 1, ACC_LOAD, 16'h7FFF, 2'd1, 2'd1);
        drive(0, 1, ACC_ADD, 16'h0001, 2'd1, 2'd1);
`ifdef ACC_SAT_EN
        check("add_ovf_out", out4, 16'h7FFF);
        check("add_ovf_flags", W'({ovf4, neg4}), 16'h0002);
`else
        check("add_ovf_out", out4, 16'h8000);
        check("add_ovf_flags", W'({ovf4, neg4}), 16'h0003);
`endif

        // SUB with borrow on acc2.
        drive(0, 1, ACC_SUB, 16'h0123, 2'd2, 2'd2);
        check("sub_out", out4, 16'hFEDD);
        check("sub_flags", W'({carry4, neg4}), 16'h0003);

        // CLR acc3 while reading acc0, then select acc3 (out of range on DEPTH=3).
        drive(0, 1, ACC_LOAD, 16'h5555, 2'd0, 2'd0);
        drive(0, 1, ACC_LOAD, 16'h1234, 2'd3, 2'd0);
        drive(0, 1, ACC_CLR,  16'hABCD, 2'd3, 2'd0);
        check("clr_keep", out4, 16'h5555);
        drive(0, 0, ACC_LOAD, 16'h0000, 2'd0, 2'd3);
        check("clr_read", out4, 16'h0000);
        check("oor_read3", out3, 16'h0000);

        // Discarded store during reset is not replayed afterwards.
        drive(1, 1, ACC_LOAD, 16'h4242, 2'd1, 2'd1);
        drive(0, 0, ACC_LOAD, 16'h4242, 2'd1, 2'd1);
        check("no_defer", out4, 16'h0000);

        // Randomised traffic biased toward boundary operands.
        for (int n = 0; n < 400; n++) begin
            logic [W-1:0] v;
            v = ($urandom_range(0, 1) == 0) ? edge_vals[$urandom_range(0, 5)] : W'($urandom);
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), v,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acc_bank.md
ACC_BANK -- requirements
Module: acc_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of every accumulator and of ALU_rez/out.
REQ-002 SHALL have parameter DEPTH, default 4, number of accumulators (>=2; need not be a power of two).
REQ-003 SHALL use one clock and a synchronous active-high reset; all state SHALL change only on the rising edge of clk.
REQ-004 SHALL have port: clk  input  1  clock.
REQ-005 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port: ALU_rez  input  WIDTH  ALU result operand.
REQ-007 SHALL have port: str_rez  input  1  store strobe; an operation executes only when it is high.
REQ-008 SHALL have port: op  input  2  operation: LOAD=00, ADD=01, SUB=10, CLR=11.
REQ-009 SHALL have port: wsel  input  clog2(DEPTH)  accumulator written.
REQ-010 SHALL have port: rsel  input  clog2(DEPTH)  accumulator driven on out.
REQ-011 SHALL have port: out  output  WIDTH  registered value of acc[rsel].
REQ-012 SHALL have ports: zero, neg, carry, ovf  output  1 each  status of the last executed store.

Function
REQ-013 On a store: LOAD writes ALU_rez; ADD writes acc+ALU_rez; SUB writes acc-ALU_rez; CLR writes 0. All results are WIDTH bits, two's complement.
REQ-014 With str_rez low, every accumulator and flag SHALL hold its value.
REQ-015 out SHALL be registered with write-through: after edge N, out = acc[rsel] including any store to the same index at edge N (latency 1 cycle).
REQ-016 A store to wsel != rsel SHALL leave out unchanged unless rsel itself changes.
REQ-017 Flags SHALL update only on an executed store and SHALL describe the written value: zero = result==0; neg = result MSB.
REQ-018 carry = carry-out for ADD, borrow (ALU_rez > acc unsigned) for SUB, 0 for LOAD/CLR.
REQ-019 ovf = signed overflow for ADD/SUB, 0 for LOAD/CLR.
REQ-020 A store with wsel >= DEPTH SHALL be ignored: no accumulator or flag changes.
REQ-021 With rsel >= DEPTH, out SHALL load 0.

Reset
REQ-022 While reset is high at an edge: all accumulators, out, zero, neg, carry and ovf SHALL become 0.
REQ-023 reset SHALL take priority over a simultaneous str_rez; the store is discarded, not deferred.

Configuration
REQ-024 When macro ACC_SAT_EN is defined, a signed-overflowing ADD/SUB SHALL write 2^(WIDTH-1)-1 (positive overflow) or -2^(WIDTH-1) (negative overflow); ovf=1 and neg/zero SHALL reflect the clamped value.
REQ-025 Without ACC_SAT_EN, ADD/SUB SHALL wrap modulo 2^WIDTH; ovf is still reported.

Structure
REQ-026 Package acc_pkg SHALL hold the op typedef/constants (ACC_LOAD, ACC_ADD, ACC_SUB, ACC_CLR) and the WIDTH/DEPTH defaults.
REQ-027 A combinational sub-module acc_alu SHALL compute the result and flags from (acc, ALU_rez, op), including the ACC_SAT_EN clamp; acc_bank holds storage, the write decode and the output register.

Verification (WIDTH=16, DEPTH=4)
REQ-028 reset=1, str_rez=1, op=LOAD, ALU_rez=0x0FFF -> after the edge, all acc=0x0000, out=0x0000, all flags 0.
REQ-029 LOAD 0xFFFF into acc0 with rsel=0, then str_rez=0 with ALU_rez=0xFF01 for 2 cycles -> out=0xFFFF throughout, neg=1, zero=0.
REQ-030 ADD 0x0001 to acc0=0xFFFF -> out=0x0000, zero=1, carry=1, ovf=0.
REQ-031 ADD 0x0001 to acc1=0x7FFF -> without ACC_SAT_EN: 0x8000, ovf=1, neg=1; with ACC_SAT_EN: 0x7FFF, ovf=1, neg=0.
REQ-032 SUB 0x0123 from acc2=0x0000 with rsel=2 -> out=0xFEDD on the edge after the store, carry=1, neg=1.
REQ-033 CLR acc3 with rsel=0 -> out keeps acc0's value; then rsel=3 -> out=0x0000 one cycle later.
